mem_arbiter: RTL and testbench

//   Shares one single-ported, fixed-latency memory between the fetch stage (IF port) and the

---
 rtl/mem_arbiter_if.sv | 36 +++
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and shared-memory signals around mem_arbiter.
// The arbiter sits on the slave modport; whoever drives requests and models the
// memory (pipeline or bench) uses the master modport.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;

    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;

    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        busy;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_ready, dm_rdata, dm_ready,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_ready, dm_rdata, dm_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-ported, fixed-latency memory between the fetch port and the
// data port. Data accesses win, except that after MAX_DSTREAK data grants in a row
// with fetch waiting, fetch is served next. Every output is a flop.
module mem_arbiter #(
    parameter int LATENCY     = 2,
    parameter int MAX_DSTREAK = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    localparam int CNT_W    = (LATENCY > 1)     ? $clog2(LATENCY)         : 1;
    localparam int STREAK_W = (MAX_DSTREAK > 0) ? $clog2(MAX_DSTREAK + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [CNT_W-1:0]    cnt;
    logic [STREAK_W-1:0] streak;
    logic                grant_dm;
    logic                lat_we;
    logic                grant_dm_now;
    logic                grant_if_now;
    logic                streak_full;
    logic                wait_done;

    assign streak_full = (streak == STREAK_W'(MAX_DSTREAK));
    assign wait_done   = (cnt == CNT_W'(LATENCY - 1));

    // State register; reset drops any access in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Arbitration decision and next-state selection.
    always_comb begin
        next_state   = state;
        grant_dm_now = 1'b0;
        grant_if_now = 1'b0;
        case (state)
            IDLE: begin
                if (bus.dm_req && !(bus.if_req && streak_full)) begin
                    grant_dm_now = 1'b1;
                    next_state   = ISSUE;
                end else if (bus.if_req) begin
                    grant_if_now = 1'b1;
                    next_state   = ISSUE;
                end
            end
            ISSUE:   next_state = (grant_dm && lat_we) ? DONE : WAIT;
            WAIT:    next_state = wait_done ? DONE : WAIT;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Latched request, streak counter, memory strobes and registered port responses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt           <= '0;
            streak        <= '0;
            grant_dm      <= 1'b0;
            lat_we        <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.if_rdata  <= '0;
            bus.if_ready  <= 1'b0;
            bus.dm_rdata  <= '0;
            bus.dm_ready  <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            bus.mem_en   <= 1'b0;
            bus.mem_we   <= 1'b0;
            bus.if_ready <= 1'b0;
            bus.dm_ready <= 1'b0;
            bus.busy     <= (next_state != IDLE);
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (grant_dm_now) begin
                        grant_dm      <= 1'b1;
                        lat_we        <= bus.dm_we;
                        bus.mem_en    <= 1'b1;
                        bus.mem_we    <= bus.dm_we;
                        bus.mem_addr  <= bus.dm_addr;
                        bus.mem_wdata <= bus.dm_wdata;
                        if (!bus.if_req) begin
                            streak <= '0;
                        end else if (!streak_full) begin
                            streak <= streak + STREAK_W'(1);
                        end
                    end else if (grant_if_now) begin
                        grant_dm     <= 1'b0;
                        lat_we       <= 1'b0;
                        bus.mem_en   <= 1'b1;
                        bus.mem_we   <= 1'b0;
                        bus.mem_addr <= bus.if_addr;
                        streak       <= '0;
                    end
                end
                ISSUE: begin
                    if (grant_dm && lat_we) begin
                        bus.dm_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    if (wait_done) begin
                        if (grant_dm) begin
                            bus.dm_rdata <= bus.mem_rdata;
                            bus.dm_ready <= 1'b1;
                        end else begin
                            bus.if_rdata <= bus.mem_rdata;
                            bus.if_ready <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a LATENCY=2 instance for the single-access table, priority,
// starvation and reset sequences, and a LATENCY=1 instance for back-to-back fetches.
module tb_mem_arbiter;

    typedef struct packed {
        logic        is_dm;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ready_cyc;
        logic [31:0] rdata;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    int n_vec  = 0;
    int n_miss = 0;

    logic [31:0] exp_if;
    logic [31:0] exp_dm;

    vec_t vecs [0:5];

    mem_arbiter_if bus_a();
    mem_arbiter_if bus_b();

    mem_arbiter #(.LATENCY(2), .MAX_DSTREAK(4)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    mem_arbiter #(.LATENCY(1), .MAX_DSTREAK(4)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    // Memory contents as seen by the arbiter: one special word, the rest address-derived.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a == 32'h40) ? 32'h8C02_0000 : (a ^ 32'hA5A5_0000);
    endfunction

    // Fixed-latency memory models plus protocol monitors, updated away from the clock edge.
    logic        pipe_a_v    [0:2] = '{1'b0, 1'b0, 1'b0};
    logic [31:0] pipe_a_addr [0:2] = '{32'h0, 32'h0, 32'h0};
    logic        pipe_b_v    [0:1] = '{1'b0, 1'b0};
    logic [31:0] pipe_b_addr [0:1] = '{32'h0, 32'h0};
    logic        prev_en_a = 1'b0;
    logic        prev_en_b = 1'b0;
    int          viol_a = 0;
    int          viol_b = 0;

    always @(negedge clk) begin
        for (int i = 2; i > 0; i--) begin
            pipe_a_v[i]    = pipe_a_v[i-1];
            pipe_a_addr[i] = pipe_a_addr[i-1];
        end
        pipe_a_v[0]     = bus_a.mem_en & ~bus_a.mem_we;
        pipe_a_addr[0]  = bus_a.mem_addr;
        bus_a.mem_rdata = pipe_a_v[2] ? mem_fn(pipe_a_addr[2]) : 32'hDEAD_BEEF;
        pipe_b_v[1]     = pipe_b_v[0];
        pipe_b_addr[1]  = pipe_b_addr[0];
        pipe_b_v[0]     = bus_b.mem_en & ~bus_b.mem_we;
        pipe_b_addr[0]  = bus_b.mem_addr;
        bus_b.mem_rdata = pipe_b_v[1] ? mem_fn(pipe_b_addr[1]) : 32'hDEAD_BEEF;
        if ((bus_a.mem_en && prev_en_a) || (bus_a.if_ready && bus_a.dm_ready)) viol_a++;
        if ((bus_b.mem_en && prev_en_b) || (bus_b.if_ready && bus_b.dm_ready)) viol_b++;
        prev_en_a = bus_a.mem_en;
        prev_en_b = bus_b.mem_en;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Runs one single-port transaction on dut_a starting in IDLE and checks it end to end.
    task automatic applyStimulus(input vec_t v, input int idx);
        int          en_cyc;
        int          rdy_cyc;
        int          other;
        logic [31:0] en_addr;
        logic [31:0] en_wdata;
        logic        en_we;
        logic [31:0] rd;
        en_cyc   = -1;
        rdy_cyc  = -1;
        other    = 0;
        en_addr  = '0;
        en_wdata = '0;
        en_we    = 1'b0;
        rd       = '0;
        if (v.is_dm) begin
            bus_a.dm_req   = 1'b1;
            bus_a.dm_we    = v.we;
            bus_a.dm_addr  = v.addr;
            bus_a.dm_wdata = v.wdata;
        end else begin
            bus_a.if_req  = 1'b1;
            bus_a.if_addr = v.addr;
        end
        for (int c = 1; c <= 20 && rdy_cyc < 0; c++) begin
            tick();
            if (bus_a.mem_en && en_cyc < 0) begin
                en_cyc   = c;
                en_addr  = bus_a.mem_addr;
                en_we    = bus_a.mem_we;
                en_wdata = bus_a.mem_wdata;
            end
            if (v.is_dm ? bus_a.if_ready : bus_a.dm_ready) other++;
            if (v.is_dm ? bus_a.dm_ready : bus_a.if_ready) begin
                rdy_cyc = c;
                rd      = v.is_dm ? bus_a.dm_rdata : bus_a.if_rdata;
            end
        end
        bus_a.dm_req = 1'b0;
        bus_a.if_req = 1'b0;
        checkOutput($sformatf("v%0d ready_cycle", idx), rdy_cyc, v.ready_cyc);
        checkOutput($sformatf("v%0d mem_en_cycle", idx), en_cyc, 1);
        checkOutput($sformatf("v%0d mem_addr", idx), en_addr, v.addr);
        checkOutput($sformatf("v%0d mem_we", idx), {31'b0, en_we}, {31'b0, v.we});
        if (v.we) checkOutput($sformatf("v%0d mem_wdata", idx), en_wdata, v.wdata);
        checkOutput($sformatf("v%0d rdata", idx), rd, v.rdata);
        checkOutput($sformatf("v%0d other_ready", idx), other, 0);
        if (v.is_dm) begin
            checkOutput($sformatf("v%0d if_rdata_held", idx), bus_a.if_rdata, exp_if);
            exp_dm = v.rdata;
        end else begin
            checkOutput($sformatf("v%0d dm_rdata_held", idx), bus_a.dm_rdata, exp_dm);
            exp_if = v.rdata;
        end
        tick();
        checkOutput($sformatf("v%0d busy_after", idx), {31'b0, bus_a.busy}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    int          d_cyc, i_cyc, ng, nr, cnt_rdy;
    logic [31:0] d_data, i_data, first_addr, b_addr;
    logic        seen_en, done;
    logic [10:0] pattern;

    initial begin
        vecs[0] = '{is_dm:1'b0, we:1'b0, addr:32'h0000_0040, wdata:32'h0,         ready_cyc:4, rdata:32'h8C02_0000};
        vecs[1] = '{is_dm:1'b1, we:1'b1, addr:32'h0000_0054, wdata:32'h7,         ready_cyc:2, rdata:32'h0000_0000};
        vecs[2] = '{is_dm:1'b1, we:1'b0, addr:32'h0000_0100, wdata:32'h0,         ready_cyc:4, rdata:32'hA5A5_0100};
        vecs[3] = '{is_dm:1'b1, we:1'b1, addr:32'h0000_0200, wdata:32'hDEAD_0001, ready_cyc:2, rdata:32'hA5A5_0100};
        vecs[4] = '{is_dm:1'b0, we:1'b0, addr:32'h0000_1234, wdata:32'h0,         ready_cyc:4, rdata:32'hA5A5_1234};
        vecs[5] = '{is_dm:1'b1, we:1'b0, addr:32'hFFFF_FFFC, wdata:32'h0,         ready_cyc:4, rdata:32'h5A5A_FFFC};

        reset = 1'b0;
        bus_a.if_req = 1'b0; bus_a.if_addr = '0;
        bus_a.dm_req = 1'b0; bus_a.dm_we = 1'b0; bus_a.dm_addr = '0; bus_a.dm_wdata = '0;
        bus_b.if_req = 1'b0; bus_b.if_addr = '0;
        bus_b.dm_req = 1'b0; bus_b.dm_we = 1'b0; bus_b.dm_addr = '0; bus_b.dm_wdata = '0;
        exp_if = '0;
        exp_dm = '0;
        repeat (3) tick();
        checkOutput("reset busy",     {31'b0, bus_a.busy},   32'h0);
        checkOutput("reset mem_en",   {31'b0, bus_a.mem_en}, 32'h0);
        checkOutput("reset if_rdata", bus_a.if_rdata,        32'h0);
        checkOutput("reset dm_rdata", bus_a.dm_rdata,        32'h0);
        checkOutput("reset readys",   {30'b0, bus_a.if_ready, bus_a.dm_ready}, 32'h0);
        reset = 1'b1;
        tick();

        $display("[TB] single-access table");
        for (int i = 0; i < 6; i++) applyStimulus(vecs[i], i);

        $display("[TB] simultaneous requests");
        bus_a.dm_req = 1'b1; bus_a.dm_we = 1'b0; bus_a.dm_addr = 32'h300;
        bus_a.if_req = 1'b1; bus_a.if_addr = 32'h44;
        d_cyc = -1; i_cyc = -1; seen_en = 1'b0; first_addr = '0; d_data = '0; i_data = '0;
        for (int c = 1; c <= 40 && i_cyc < 0; c++) begin
            tick();
            if (bus_a.mem_en && !seen_en) begin
                first_addr = bus_a.mem_addr;
                seen_en    = 1'b1;
            end
            if (bus_a.dm_ready) begin
                d_cyc = c; d_data = bus_a.dm_rdata; bus_a.dm_req = 1'b0;
            end
            if (bus_a.if_ready) begin
                i_cyc = c; i_data = bus_a.if_rdata; bus_a.if_req = 1'b0;
            end
        end
        bus_a.dm_req = 1'b0;
        bus_a.if_req = 1'b0;
        tick();
        checkOutput("s3 first grant addr", first_addr, 32'h300);
        checkOutput("s3 dm_ready cycle",   d_cyc,      4);
        checkOutput("s3 dm_rdata",         d_data,     32'hA5A5_0300);
        checkOutput("s3 if_ready cycle",   i_cyc,      9);
        checkOutput("s3 if_rdata",         i_data,     32'hA5A5_0044);

        $display("[TB] fetch starvation guard");
        bus_a.dm_req = 1'b1; bus_a.dm_we = 1'b1; bus_a.dm_addr = 32'h500; bus_a.dm_wdata = 32'h11;
        bus_a.if_req = 1'b1; bus_a.if_addr = 32'h600;
        pattern = '0; ng = 0; done = 1'b0;
        for (int c = 1; c <= 150 && !done; c++) begin
            tick();
            if (bus_a.mem_en && ng < 11) begin
                pattern[10-ng] = bus_a.mem_we;
                ng++;
            end
            if (bus_a.if_ready) checkOutput("s4 if_rdata", bus_a.if_rdata, 32'hA5A5_0600);
            if (ng == 11 && bus_a.dm_ready) done = 1'b1;
        end
        bus_a.dm_req = 1'b0;
        bus_a.if_req = 1'b0;
        tick();
        checkOutput("s4 grant count",   ng,      11);
        checkOutput("s4 grant order",   {21'b0, pattern}, {21'b0, 11'b11110_11110_1});
        checkOutput("s4 busy after",    {31'b0, bus_a.busy}, 32'h0);

        $display("[TB] reset during read wait");
        bus_a.dm_req = 1'b1; bus_a.dm_we = 1'b0; bus_a.dm_addr = 32'h700;
        tick();
        tick();
        checkOutput("s5 busy in wait", {31'b0, bus_a.busy}, 32'h1);
        reset = 1'b0;
        #1;
        checkOutput("s5 busy",     {31'b0, bus_a.busy},   32'h0);
        checkOutput("s5 mem_addr", bus_a.mem_addr,        32'h0);
        checkOutput("s5 dm_rdata", bus_a.dm_rdata,        32'h0);
        checkOutput("s5 if_rdata", bus_a.if_rdata,        32'h0);
        checkOutput("s5 mem_en",   {31'b0, bus_a.mem_en}, 32'h0);
        bus_a.dm_req = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        cnt_rdy = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (bus_a.dm_ready || bus_a.if_ready || bus_a.busy) cnt_rdy++;
        end
        checkOutput("s5 activity after release", cnt_rdy, 0);
        exp_if = '0;
        exp_dm = '0;
        applyStimulus(vecs[0], 6);

        $display("[TB] LATENCY=1 back-to-back fetches");
        nr = 0;
        b_addr = 32'h800;
        bus_b.if_req = 1'b1;
        bus_b.if_addr = b_addr;
        for (int c = 1; c <= 40 && nr < 5; c++) begin
            tick();
            if (bus_b.if_ready) begin
                checkOutput($sformatf("s6 read%0d cycle", nr), c, 3 + 4 * nr);
                checkOutput($sformatf("s6 read%0d data", nr), bus_b.if_rdata, mem_fn(b_addr));
                nr++;
                b_addr = b_addr + 32'h4;
                if (nr < 5) bus_b.if_addr = b_addr;
                else bus_b.if_req = 1'b0;
            end
        end
        bus_b.if_req = 1'b0;
        tick();
        checkOutput("s6 reads completed", nr, 5);

        checkOutput("monitor a violations", viol_a, 0);
        checkOutput("monitor b violations", viol_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
